// File: rtl/loopback_pkg.sv
// Shared types and constants for the loopback delay emulator.
// Optional dither is enabled by defining LOOPBACK_DITHER_EN.
package loopback_pkg;

    localparam int unsigned MAGNITUD_WIDTH = 14;

    typedef logic signed [MAGNITUD_WIDTH-1:0] sample_t;

    localparam sample_t ZERO_MAG   = '0;
    localparam sample_t SAMPLE_MAX = {1'b0, {(MAGNITUD_WIDTH-1){1'b1}}};

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        CFG_IDLE  = 1'b0,
        CFG_APPLY = 1'b1
    } cfg_state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/loopback_tap.sv
// One output channel: delayed read from the shared buffer, history mute,
// arithmetic-shift attenuation, optional dither (LOOPBACK_DITHER_EN) and
// output register.
module loopback_tap
    import loopback_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned SHIFT_W = 2,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic               clk125,
    input  logic               areset,
    input  logic               din_valid,
    input  sample_t            din,
    input  sample_t            mem [DEPTH],
    input  logic [AW-1:0]      wr_ptr,
    input  logic [AW:0]        fill_cnt,
    input  logic [AW-1:0]      delay,
    input  logic [SHIFT_W-1:0] shift,
`ifdef LOOPBACK_DITHER_EN
    input  logic               dither_bit,
`endif
    output sample_t            dout
);

    logic [AW-1:0] rd_addr_c;
    logic          mute_c;
    sample_t       s_c;
    sample_t       shifted_c;
    sample_t       out_c;
    sample_t       dout_d;
    sample_t       dout_q;

    // Select the delayed sample (pre-write contents), mute, attenuate
    always_comb begin
        rd_addr_c = wr_ptr - delay;
        mute_c    = fill_cnt < {1'b0, delay};
        s_c       = (delay == '0) ? din : mem[rd_addr_c];
        if (mute_c) begin
            s_c = ZERO_MAG;
        end
        shifted_c = s_c >>> shift;
        out_c     = shifted_c;
`ifdef LOOPBACK_DITHER_EN
        if (dither_bit && !mute_c && (shifted_c != SAMPLE_MAX)) begin
            out_c = shifted_c + sample_t'(1);
        end
`endif
        dout_d = dout_q;
        if (din_valid) begin
            dout_d = out_c;
        end
    end

    // Output register, holds between strobes
    always_ff @(posedge clk125 or posedge areset) begin
        if (areset) begin
            dout_q <= ZERO_MAG;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/loopback_delay_emulator.sv
// Multi-channel loopback delay emulator: shared circular sample buffer,
// fill counter, config FSM and N_CH output taps.
// Define LOOPBACK_DITHER_EN to add LFSR dither to every channel.
module loopback_delay_emulator
    import loopback_pkg::*;
#(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned SHIFT_W = 2,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                             clk125,
    input  logic                             areset,
    input  logic [MAGNITUD_WIDTH-1:0]        din,
    input  logic                             din_valid,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [CH_W-1:0]                  cfg_ch,
    input  logic [AW-1:0]                    cfg_delay,
    input  logic [SHIFT_W-1:0]               cfg_shift,
    output logic [N_CH*MAGNITUD_WIDTH-1:0]   dout,
    output logic                             dout_valid,
    output logic                             cfg_busy
);

    localparam int unsigned FILL_W = AW + 1;

    sample_t            mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_d,  wr_ptr_q;
    logic [FILL_W-1:0]  fill_d,    fill_q;
    logic               dout_valid_q;

    cfg_state_e         state_d,   state_q;
    logic [CH_W-1:0]    cfg_ch_d,  cfg_ch_q;
    logic [AW-1:0]      cfg_dly_d, cfg_dly_q;
    logic [SHIFT_W-1:0] cfg_sh_d,  cfg_sh_q;
    logic [AW-1:0]      delay_d [N_CH];
    logic [AW-1:0]      delay_q [N_CH];
    logic [SHIFT_W-1:0] shift_d [N_CH];
    logic [SHIFT_W-1:0] shift_q [N_CH];
    logic               cfg_ready_d, cfg_ready_q;
    logic               cfg_busy_d,  cfg_busy_q;

    // Sample buffer write; contents are deliberately not reset
    always_ff @(posedge clk125) begin
        if (din_valid) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Write pointer and saturating fill counter advance per sample
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (din_valid) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (fill_q != FILL_W'(DEPTH)) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    // Config FSM: latch request in IDLE, commit to channel registers in APPLY
    always_comb begin
        state_d   = state_q;
        cfg_ch_d  = cfg_ch_q;
        cfg_dly_d = cfg_dly_q;
        cfg_sh_d  = cfg_sh_q;
        delay_d   = delay_q;
        shift_d   = shift_q;
        case (state_q)
            CFG_IDLE: begin
                if (cfg_valid) begin
                    cfg_ch_d  = cfg_ch;
                    cfg_dly_d = cfg_delay;
                    cfg_sh_d  = cfg_shift;
                    state_d   = CFG_APPLY;
                end
            end
            CFG_APPLY: begin
                for (int unsigned c = 0; c < N_CH; c++) begin
                    if (32'(cfg_ch_q) == c) begin
                        delay_d[c] = cfg_dly_q;
                        shift_d[c] = cfg_sh_q;
                    end
                end
                state_d = CFG_IDLE;
            end
            default: state_d = CFG_IDLE;
        endcase
        cfg_ready_d = (state_d == CFG_IDLE);
        cfg_busy_d  = (state_d == CFG_APPLY);
    end

    // State and control registers
    always_ff @(posedge clk125 or posedge areset) begin
        if (areset) begin
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            dout_valid_q <= 1'b0;
            state_q      <= CFG_IDLE;
            cfg_ch_q     <= '0;
            cfg_dly_q    <= '0;
            cfg_sh_q     <= '0;
            cfg_ready_q  <= 1'b1;
            cfg_busy_q   <= 1'b0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                delay_q[c] <= '0;
                shift_q[c] <= '0;
            end
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            dout_valid_q <= din_valid;
            state_q      <= state_d;
            cfg_ch_q     <= cfg_ch_d;
            cfg_dly_q    <= cfg_dly_d;
            cfg_sh_q     <= cfg_sh_d;
            cfg_ready_q  <= cfg_ready_d;
            cfg_busy_q   <= cfg_busy_d;
            delay_q      <= delay_d;
            shift_q      <= shift_d;
        end
    end

`ifdef LOOPBACK_DITHER_EN
    logic [15:0] lfsr_d, lfsr_q;

    // Dither source advances once per accepted sample
    always_comb begin
        lfsr_d = lfsr_q;
        if (din_valid) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // LFSR register
    always_ff @(posedge clk125 or posedge areset) begin
        if (areset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    for (genvar c = 0; c < N_CH; c++) begin : g_tap
        loopback_tap #(
            .DEPTH   (DEPTH),
            .SHIFT_W (SHIFT_W)
        ) u_tap (
            .clk125     (clk125),
            .areset     (areset),
            .din_valid  (din_valid),
            .din        (sample_t'(din)),
            .mem        (mem_q),
            .wr_ptr     (wr_ptr_q),
            .fill_cnt   (fill_q),
            .delay      (delay_q[c]),
            .shift      (shift_q[c]),
`ifdef LOOPBACK_DITHER_EN
            .dither_bit (lfsr_q[0]),
`endif
            .dout       (dout[c*MAGNITUD_WIDTH +: MAGNITUD_WIDTH])
        );
    end

    assign dout_valid = dout_valid_q;
    assign cfg_ready  = cfg_ready_q;
    assign cfg_busy   = cfg_busy_q;

endmodule

// File: tb/tb_loopback_delay_emulator.sv
// Directed self-checking bench for loopback_delay_emulator (default build).
// Three channels are instantiated so that an out-of-range cfg_ch is encodable.
module tb_loopback_delay_emulator;
    import loopback_pkg::*;

    localparam int unsigned N_CH    = 3;
    localparam int unsigned DEPTH   = 64;
    localparam int unsigned SHIFT_W = 2;
    localparam int unsigned MW      = MAGNITUD_WIDTH;

    logic                 clk125 = 1'b0;
    logic                 areset = 1'b0;
    logic [MW-1:0]        din = '0;
    logic                 din_valid = 1'b0;
    logic                 cfg_valid = 1'b0;
    logic                 cfg_ready;
    logic [1:0]           cfg_ch = '0;
    logic [5:0]           cfg_delay = '0;
    logic [SHIFT_W-1:0]   cfg_shift = '0;
    logic [N_CH*MW-1:0]   dout;
    logic                 dout_valid;
    logic                 cfg_busy;

    int checks = 0;
    int errors = 0;

    loopback_delay_emulator #(
        .N_CH    (N_CH),
        .DEPTH   (DEPTH),
        .SHIFT_W (SHIFT_W)
    ) dut (
        .clk125     (clk125),
        .areset     (areset),
        .din        (din),
        .din_valid  (din_valid),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_delay  (cfg_delay),
        .cfg_shift  (cfg_shift),
        .dout       (dout),
        .dout_valid (dout_valid),
        .cfg_busy   (cfg_busy)
    );

    always #4 clk125 = ~clk125;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] ch(input int c);
        sample_t v;
        v = dout[c*MW +: MW];
        return v;
    endfunction

    function automatic int expv(input int k, input int d, input int s);
        if (k < d) return 0;
        return (k - d) >>> s;
    endfunction

    task automatic tick;
        @(posedge clk125);
        #1;
    endtask

    task automatic do_reset;
        areset = 1'b1;
        #1;
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_ch0", ch(0), 0);
        chk("rst_ch1", ch(1), 0);
        chk("rst_ch2", ch(2), 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_cfg_busy", cfg_busy, 0);
        tick();
        areset = 1'b0;
    endtask

    task automatic cfg(input int ch_i, input int d, input int s);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch_i);
        cfg_delay = 6'(d);
        cfg_shift = 2'(s);
        chk("cfg_ready_idle", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        chk("cfg_ready_apply", cfg_ready, 0);
        chk("cfg_busy_apply", cfg_busy, 1);
        tick();
        chk("cfg_ready_back", cfg_ready, 1);
        chk("cfg_busy_back", cfg_busy, 0);
    endtask

    // Ramp din=k for k in [k0, k0+n); ch2 is always an undelayed pass-through
    task automatic run(input int k0, input int n, input int d0, input int s0,
                       input int d1, input int s1);
        for (int k = k0; k < k0 + n; k++) begin
            din_valid = 1'b1;
            din       = MW'(k);
            tick();
            chk($sformatf("dv k=%0d", k), dout_valid, 1);
            chk($sformatf("ch0 k=%0d", k), ch(0), expv(k, d0, s0));
            chk($sformatf("ch1 k=%0d", k), ch(1), expv(k, d1, s1));
            chk($sformatf("ch2 k=%0d", k), ch(2), k);
        end
        din_valid = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();

        // Basic delays and attenuation
        cfg(0, 20, 0);
        cfg(1, 30, 2);
        run(0, 200, 20, 0, 30, 2);
        tick();
        chk("idle_dv", dout_valid, 0);
        chk("hold_ch0", ch(0), 179);
        chk("hold_ch1", ch(1), 42);

        // Negative sample, sign-preserving shift
        do_reset();
        cfg(0, 5, 2);
        for (int k = 0; k < 10; k++) begin
            din_valid = 1'b1;
            din       = 14'h2000;
            tick();
            chk($sformatf("neg ch0 k=%0d", k), ch(0), (k < 5) ? 0 : -2048);
            chk($sformatf("neg ch1 k=%0d", k), ch(1), -8192);
        end
        din_valid = 1'b0;

        // Maximum delay across several pointer wraps
        do_reset();
        cfg(0, 63, 0);
        run(0, 300, 63, 0, 0, 0);

        // Delay 0 and delay 3 with alternating gaps
        do_reset();
        cfg(1, 3, 0);
        for (int i = 0; i < 40; i++) begin
            int k;
            k = i / 2;
            if (i % 2 == 0) begin
                din_valid = 1'b1;
                din       = MW'(100 + k);
            end else begin
                din_valid = 1'b0;
                din       = MW'(777);
            end
            tick();
            chk($sformatf("gap dv i=%0d", i), dout_valid, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("gap ch0 i=%0d", i), ch(0), 100 + k);
            chk($sformatf("gap ch1 i=%0d", i), ch(1), (k < 3) ? 0 : 97 + k);
        end
        din_valid = 1'b0;

        // Reconfigure ch1 10 -> 40 while streaming
        do_reset();
        cfg(1, 10, 0);
        run(0, 50, 0, 0, 10, 0);
        din_valid = 1'b1;
        din       = MW'(50);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_delay = 6'd40;
        cfg_shift = 2'd0;
        chk("rc_ready_pre", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        chk("rc_ch1_k50", ch(1), 40);
        chk("rc_ready_k50", cfg_ready, 0);
        chk("rc_busy_k50", cfg_busy, 1);
        din = MW'(51);
        tick();
        chk("rc_ch1_k51", ch(1), 41);
        chk("rc_ready_k51", cfg_ready, 1);
        chk("rc_busy_k51", cfg_busy, 0);
        run(52, 28, 0, 0, 40, 0);
        cfg(3, 5, 1);
        run(80, 10, 0, 0, 40, 0);

        // Reset asserted mid-stream at sample 150
        do_reset();
        cfg(0, 20, 0);
        cfg(1, 30, 2);
        run(0, 150, 20, 0, 30, 2);
        din_valid = 1'b1;
        din       = MW'(150);
        do_reset();
        run(0, 40, 0, 0, 0, 0);

        // Reset while a config is in APPLY
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_delay = 6'd7;
        cfg_shift = 2'd1;
        tick();
        cfg_valid = 1'b0;
        chk("abort_busy", cfg_busy, 1);
        do_reset();
        run(0, 10, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/loopback_delay_emulator.md
Name: loopback_delay_emulator

Overview:
- Synthesizable multi-channel loopback channel emulator for the DDS measurement path.
- Takes the DAC sample stream and produces N_CH delayed, attenuated copies to drive the ADC inputs of the control path in bench and on-board self-test.
- Per-channel delay (in samples) and attenuation are programmable at runtime through a config handshake.
- Replaces fixed compile-time shift-register delays.

Parameters:
- MAGNITUD_WIDTH, 14, sample width (signed two's complement).
- N_CH, 2, number of output channels.
- DEPTH, 64, buffer depth; max delay is DEPTH-1 samples; must be a power of 2.
- SHIFT_W, 2, width of the per-channel arithmetic-right-shift attenuation field.

Ports:
- clk125  input  1  sample clock.
- areset  input  1  asynchronous reset, active-high.
- din  input  MAGNITUD_WIDTH  signed DAC sample.
- din_valid  input  1  sample strobe; one sample per asserted cycle.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config accepted when high together with cfg_valid.
- cfg_ch  input  max(1,$clog2(N_CH))  target channel.
- cfg_delay  input  $clog2(DEPTH)  delay in samples, 0..DEPTH-1.
- cfg_shift  input  SHIFT_W  attenuation, output = sample >>> shift.
- dout  output  N_CH*MAGNITUD_WIDTH  channel c occupies bits [c*MW +: MW].
- dout_valid  output  1  one-cycle strobe, shared by all channels.
- cfg_busy  output  1  high while a config is being applied.

Behaviour:
- Clock and reset: one clock (clk125). Reset (areset) is asynchronous and active-high.
- Reset values:
  - wr_ptr=0, fill_cnt=0.
  - All delay_c=0 and shift_c=0.
  - dout=0, dout_valid=0, cfg_ready=1, cfg_busy=0, FSM=IDLE.
  - Buffer RAM contents are not reset.
- Buffer and counters:
  - Shared circular buffer, DEPTH x MAGNITUD_WIDTH.
  - On din_valid: buf[wr_ptr] <= din; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
  - fill_cnt increments on each din_valid and saturates at DEPTH.
- Read path (channel c, on din_valid with current sample k):
  - Select s = din when delay_c==0; otherwise s = buf[(wr_ptr - delay_c) mod DEPTH].
  - The read uses pre-write contents, so s equals sample k-delay_c.
- Mute:
  - If fill_cnt < delay_c (history not yet written since reset), s is forced to 0.
  - Otherwise use s as read.
- Output:
  - dout_c <= s >>> shift_c (sign-preserving).
  - dout_valid <= din_valid.
  - Latency is 1 cycle from din_valid to dout_valid.
  - dout holds its value between strobes.
- Delay counts samples, not cycles; gaps in din_valid do not advance the delay.
- Config FSM, IDLE -> APPLY -> IDLE:
  - IDLE: cfg_ready=1. On cfg_valid, latch cfg_ch/cfg_delay/cfg_shift and go to APPLY.
  - APPLY: cfg_ready=0, cfg_busy=1; write delay_c/shift_c at the end of the cycle; return to IDLE.
  - A config accepted in cycle t affects din_valid samples from t+2 onward. A din_valid in t or t+1 uses the old values.
  - If cfg_ch >= N_CH, the handshake completes and the write is dropped.
  - A config does not clear fill_cnt; buffer history is real data.
- Reset asserted mid-operation:
  - dout and dout_valid go to 0 immediately.
  - Any APPLY in progress is abandoned.
  - Muting restarts from fill_cnt=0.

Optional Feature:
- Macro LOOPBACK_DITHER_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per din_valid.
  - Its bit 0 is added as +1 LSB to each channel's shifted output.
  - The sum saturates at the maximum positive value.
  - Muted samples stay exactly 0.
- When undefined: no LFSR is instantiated and the output is exactly s >>> shift_c.

Decomposition:
- Package loopback_pkg holds:
  - typedef sample_t, signed [MAGNITUD_WIDTH-1:0];
  - constant ZERO_MAG;
  - LFSR_SEED and LFSR tap constants.
- One sub-module, loopback_tap, instantiated N_CH times via generate. It contains:
  - read-address computation;
  - mute compare;
  - shift;
  - optional dither/saturation;
  - output register.
- The top module holds the buffer, pointers, fill counter and config FSM.

Test Plan:
- Basic delays and attenuation:
  - Stimulus: reset; configure ch0 delay=20 shift=0 and ch1 delay=30 shift=2; then drive din=k (k=0..199) every cycle.
  - Response: ch0 = 0 for k<20, then k-20. ch1 = 0 for k<30, then (k-30)>>>2. Each result appears one cycle after the corresponding din_valid.
- Negative sign extension:
  - Stimulus: din=-8192 constant, ch0 shift=2 delay=5.
  - Response: dout_ch0 = -2048 after 5 samples.
- Wrap-around:
  - Stimulus: delay=63, 300 ramp samples.
  - Response: dout = k-63 for all k>=63, across several wr_ptr wraps.
- Delay 0 and input gaps:
  - Stimulus: delay=0; din_valid alternating 1/0.
  - Response: dout equals din one cycle later. dout_valid follows din_valid. Delay=3 with gaps still yields sample k-3.
- Reconfig during streaming:
  - Stimulus: cfg_valid for ch1 delay 10->40 in the same cycle as din_valid.
  - Response: that sample and the next use delay 10; cfg_ready is low for one cycle; later samples read k-40. cfg_ch=3 is accepted and has no effect.
- Reset mid-stream:
  - Stimulus: assert areset at sample 150, release, resume the ramp from k=0.
  - Response: dout=0 and dout_valid=0 immediately. Outputs are muted until fill_cnt reaches delay_c; all delays read back as 0, so the output is a pass-through.
